// File: rtl/register_bank_write_arbiter_pkg.sv
// rtl/register_bank_write_arbiter_pkg.sv - shared defaults and grant encoding for bank write arbiters
package register_bank_write_arbiter_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_NREG  = 4;
  localparam int DEFAULT_ADDRW = 2;

  // Encoding of which writer was granted most recently
  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

endpackage

// File: rtl/register_bank_write_arbiter_if.sv
// rtl/register_bank_write_arbiter_if.sv - two-writer request bus plus shared bank drive signals
interface register_bank_write_arbiter_if #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int ADDRW = 2
) ();

  logic             ReqA;
  logic [ADDRW-1:0] AddrA;
  logic [WIDTH-1:0] DataA;
  logic             AckA;

  logic             ReqB;
  logic [ADDRW-1:0] AddrB;
  logic [WIDTH-1:0] DataB;
  logic             AckB;

  logic [WIDTH-1:0] Dout;
  logic [NREG-1:0]  Enbar;
  logic             Err;

  // Arbiter side: consumes requests, drives acks and the bank
  modport master (
    input  ReqA, AddrA, DataA, ReqB, AddrB, DataB,
    output AckA, AckB, Dout, Enbar, Err
  );

  // Writer/bank side
  modport slave (
    output ReqA, AddrA, DataA, ReqB, AddrB, DataB,
    input  AckA, AckB, Dout, Enbar, Err
  );

endinterface

// File: rtl/register_bank_write_arbiter_rr_arbiter2.sv
// rtl/register_bank_write_arbiter_rr_arbiter2.sv - combinational two-way round-robin grant
module rr_arbiter2
  import register_bank_write_arbiter_pkg::*;
(
  input  logic       eligA,
  input  logic       eligB,
  input  grant_t     grantLast,
  output logic [1:0] grant
);

  // A wins when alone or when B was served last; B symmetrically
  assign grant[0] = eligA & (~eligB | (grantLast == GRANT_B));
  assign grant[1] = eligB & (~eligA | (grantLast == GRANT_A));

endmodule

// File: rtl/register_bank_write_arbiter.sv
// rtl/register_bank_write_arbiter.sv - round-robin arbiter sharing one negedge register bank between two writers
module register_bank_write_arbiter
  import register_bank_write_arbiter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int NREG  = DEFAULT_NREG,
  parameter int ADDRW = DEFAULT_ADDRW
) (
  input logic ClkN,
  input logic Clr,
  register_bank_write_arbiter_if.master bus
);

  logic             ackA;
  logic             ackB;
  logic             err;
  logic [WIDTH-1:0] dout;
  logic [NREG-1:0]  enbar;
  grant_t           grantLast;

  logic             eligA;
  logic             eligB;
  logic [1:0]       grant;
  logic [ADDRW-1:0] selAddr;
  logic [WIDTH-1:0] selData;
  logic             inRange;
  logic [NREG-1:0]  enbarDec;

  // A writer acked on the previous edge is still holding its old request; skip it once
  assign eligA = bus.ReqA & ~ackA;
  assign eligB = bus.ReqB & ~ackB;

  rr_arbiter2 uArb (
    .eligA     (eligA),
    .eligB     (eligB),
    .grantLast (grantLast),
    .grant     (grant)
  );

  // Select the granted writer's address/data and decode it to a one-hot active-low enable
  always_comb begin
    selAddr  = grant[1] ? bus.AddrB : bus.AddrA;
    selData  = grant[1] ? bus.DataB : bus.DataA;
    inRange  = (32'(selAddr) < NREG);
    enbarDec = '1;
    for (int i = 0; i < NREG; i++) begin
      if (32'(selAddr) == i) begin
        enbarDec[i] = 1'b0;
      end
    end
  end

  // Output registers; reset drops any pending load enable immediately
  always_ff @(negedge ClkN or posedge Clr) begin
    if (Clr) begin
      ackA      <= 1'b0;
      ackB      <= 1'b0;
      err       <= 1'b0;
      dout      <= '0;
      enbar     <= '1;
      grantLast <= GRANT_B;
    end else if (grant != 2'b00) begin
      ackA      <= grant[0];
      ackB      <= grant[1];
      grantLast <= grant[1] ? GRANT_B : GRANT_A;
      if (inRange) begin
        dout  <= selData;
        enbar <= enbarDec;
        err   <= 1'b0;
      end else begin
        enbar <= '1;
        err   <= 1'b1;
      end
    end else begin
      ackA  <= 1'b0;
      ackB  <= 1'b0;
      err   <= 1'b0;
      enbar <= '1;
    end
  end

  assign bus.AckA  = ackA;
  assign bus.AckB  = ackB;
  assign bus.Err   = err;
  assign bus.Dout  = dout;
  assign bus.Enbar = enbar;

endmodule

// File: tb/tb_register_bank_write_arbiter.sv
// tb/tb_register_bank_write_arbiter.sv - self-checking bench for register_bank_write_arbiter
module tb_register_bank_write_arbiter;

  logic clkN = 1'b1;
  logic clr;
  int   tests = 0;
  int   failed = 0;

  always #5 clkN = ~clkN;

  register_bank_write_arbiter_if #(.WIDTH(8), .NREG(4), .ADDRW(2)) bus4 ();
  register_bank_write_arbiter_if #(.WIDTH(8), .NREG(3), .ADDRW(2)) bus3 ();

  register_bank_write_arbiter #(.WIDTH(8), .NREG(4), .ADDRW(2)) dut4 (
    .ClkN (clkN),
    .Clr  (clr),
    .bus  (bus4)
  );

  register_bank_write_arbiter #(.WIDTH(8), .NREG(3), .ADDRW(2)) dut3 (
    .ClkN (clkN),
    .Clr  (clr),
    .bus  (bus3)
  );

  // Bank of negedge registers with active-low load, plus a behavioural arbiter model
  logic [7:0] bank4 [4];
  logic [7:0] mBank [4];
  bit         mLastB;
  bit         mAckA, mAckB, mErr;
  logic [3:0] mEnbar;
  logic [7:0] mDout;
  bit         pendValid;
  int         pendAddr;
  logic [7:0] pendData;

  initial begin
    for (int i = 0; i < 4; i++) begin
      bank4[i] = 8'h00;
      mBank[i] = 8'h00;
    end
    pendValid = 0;
  end

  always @(negedge clkN) begin
    int winner;
    bit eA, eB;
    for (int i = 0; i < 4; i++) begin
      if (!bus4.Enbar[i]) bank4[i] = bus4.Dout;
    end
    if (clr) begin
      mLastB = 1; mAckA = 0; mAckB = 0; mErr = 0;
      mEnbar = 4'hF; mDout = 8'h00; pendValid = 0;
    end else begin
      if (pendValid) mBank[pendAddr] = pendData;
      pendValid = 0;
      eA = bus4.ReqA && !mAckA;
      eB = bus4.ReqB && !mAckB;
      if (eA && eB) winner = mLastB ? 0 : 1;
      else if (eA) winner = 0;
      else if (eB) winner = 1;
      else winner = -1;
      mAckA = (winner == 0);
      mAckB = (winner == 1);
      mErr = 0;
      mEnbar = 4'hF;
      if (winner >= 0) begin
        mLastB = (winner == 1);
        pendAddr = (winner == 0) ? int'(bus4.AddrA) : int'(bus4.AddrB);
        pendData = (winner == 0) ? bus4.DataA : bus4.DataB;
        if (pendAddr < 4) begin
          mDout = pendData;
          mEnbar[pendAddr] = 1'b0;
          pendValid = 1;
        end else begin
          mErr = 1;
        end
      end
    end
  end

  function automatic logic [31:0] out4();
    return {17'b0, bus4.AckA, bus4.AckB, bus4.Err, bus4.Enbar, bus4.Dout};
  endfunction

  function automatic logic [31:0] out3();
    return {18'b0, bus3.AckA, bus3.AckB, bus3.Err, bus3.Enbar, bus3.Dout};
  endfunction

  function automatic logic [31:0] exp4(bit a, bit b, bit e, logic [3:0] en, logic [7:0] d);
    return {17'b0, a, b, e, en, d};
  endfunction

  function automatic logic [31:0] exp3(bit a, bit b, bit e, logic [2:0] en, logic [7:0] d);
    return {18'b0, a, b, e, en, d};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bankWord();
    return {bank4[3], bank4[2], bank4[1], bank4[0]};
  endfunction

  task automatic drive4(bit ra, logic [1:0] aa, logic [7:0] da, bit rb, logic [1:0] ab, logic [7:0] db);
    bus4.ReqA = ra; bus4.AddrA = aa; bus4.DataA = da;
    bus4.ReqB = rb; bus4.AddrB = ab; bus4.DataB = db;
  endtask

  typedef struct {
    bit         reqA;
    logic [1:0] addrA;
    logic [7:0] dataA;
    bit         reqB;
    logic [1:0] addrB;
    logic [7:0] dataB;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [11];

  initial begin
    bit   holdA, holdB;
    logic [7:0] oldReg3;

    vecs[0]  = '{1, 2'd2, 8'h5A, 0, 2'd0, 8'h00, exp4(1, 0, 0, 4'b1011, 8'h5A)};
    vecs[1]  = '{0, 2'd0, 8'h00, 0, 2'd0, 8'h00, exp4(0, 0, 0, 4'b1111, 8'h5A)};
    vecs[2]  = '{1, 2'd0, 8'h11, 1, 2'd1, 8'h22, exp4(0, 1, 0, 4'b1101, 8'h22)};
    vecs[3]  = '{1, 2'd0, 8'h11, 1, 2'd1, 8'h22, exp4(1, 0, 0, 4'b1110, 8'h11)};
    vecs[4]  = '{1, 2'd0, 8'h11, 1, 2'd1, 8'h22, exp4(0, 1, 0, 4'b1101, 8'h22)};
    vecs[5]  = '{1, 2'd0, 8'h11, 0, 2'd0, 8'h00, exp4(1, 0, 0, 4'b1110, 8'h11)};
    vecs[6]  = '{1, 2'd0, 8'h11, 0, 2'd0, 8'h00, exp4(0, 0, 0, 4'b1111, 8'h11)};
    vecs[7]  = '{1, 2'd3, 8'h33, 0, 2'd0, 8'h00, exp4(1, 0, 0, 4'b0111, 8'h33)};
    vecs[8]  = '{0, 2'd0, 8'h00, 1, 2'd2, 8'h44, exp4(0, 1, 0, 4'b1011, 8'h44)};
    vecs[9]  = '{1, 2'd1, 8'h55, 1, 2'd2, 8'h44, exp4(1, 0, 0, 4'b1101, 8'h55)};
    vecs[10] = '{0, 2'd0, 8'h00, 0, 2'd0, 8'h00, exp4(0, 0, 0, 4'b1111, 8'h55)};

    clr = 1'b1;
    drive4(1, 2'd0, 8'h11, 1, 2'd1, 8'h22);
    bus3.ReqA = 1; bus3.AddrA = 2'd0; bus3.DataA = 8'h01;
    bus3.ReqB = 1; bus3.AddrB = 2'd1; bus3.DataB = 8'h02;

    // Reset holds everything idle even with both writers requesting
    for (int i = 0; i < 3; i++) begin
      @(posedge clkN);
      check("reset_out4", out4(), exp4(0, 0, 0, 4'b1111, 8'h00));
      check("reset_out3", out3(), exp3(0, 0, 0, 3'b111, 8'h00));
    end
    clr = 1'b0;
    bus3.ReqA = 0; bus3.ReqB = 0;

    // Continuous contention: A first after reset, then strict alternation
    for (int i = 0; i < 4; i++) begin
      @(posedge clkN);
      if (i % 2 == 0) check("contend_A", out4(), exp4(1, 0, 0, 4'b1110, 8'h11));
      else            check("contend_B", out4(), exp4(0, 1, 0, 4'b1101, 8'h22));
    end
    drive4(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    @(posedge clkN);
    check("contend_bank", bankWord(), {8'h00, 8'h00, 8'h22, 8'h11});

    // Table-driven sequence
    for (int i = 0; i < 11; i++) begin
      drive4(vecs[i].reqA, vecs[i].addrA, vecs[i].dataA, vecs[i].reqB, vecs[i].addrB, vecs[i].dataB);
      @(posedge clkN);
      check($sformatf("vec%0d", i), out4(), vecs[i].exp);
      if (i == 1) check("single_write_bank2", {24'b0, bank4[2]}, 32'h5A);
    end
    check("table_bank", bankWord(), {8'h33, 8'h44, 8'h55, 8'h11});

    // Out-of-range address on the three-register build
    bus3.ReqB = 1; bus3.AddrB = 2'd1; bus3.DataB = 8'h77;
    @(posedge clkN);
    check("oor_setup", out3(), exp3(0, 1, 0, 3'b101, 8'h77));
    bus3.AddrB = 2'd3; bus3.DataB = 8'h99;
    @(posedge clkN);
    check("oor_ackgap", out3(), exp3(0, 0, 0, 3'b111, 8'h77));
    @(posedge clkN);
    check("oor_err", out3(), exp3(0, 1, 1, 3'b111, 8'h77));
    bus3.ReqB = 0;
    @(posedge clkN);
    check("oor_clear", out3(), exp3(0, 0, 0, 3'b111, 8'h77));

    // Reset mid-grant cancels the pending load immediately
    oldReg3 = bank4[3];
    drive4(1, 2'd3, 8'hCC, 0, 2'd0, 8'h00);
    @(posedge clkN);
    check("midgrant_pre", out4(), exp4(1, 0, 0, 4'b0111, 8'hCC));
    #2 clr = 1'b1;
    #1 check("midgrant_cancel", out4(), exp4(0, 0, 0, 4'b1111, 8'h00));
    drive4(0, 2'd0, 8'h00, 0, 2'd0, 8'h00);
    @(posedge clkN);
    check("midgrant_reg3", {24'b0, bank4[3]}, {24'b0, oldReg3});

    // Same-address race right after reset: later write (B) wins
    drive4(1, 2'd3, 8'hAA, 1, 2'd3, 8'hBB);
    clr = 1'b0;
    @(posedge clkN);
    check("race_A", out4(), exp4(1, 0, 0, 4'b0111, 8'hAA));
    bus4.ReqA = 0;
    @(posedge clkN);
    check("race_B", out4(), exp4(0, 1, 0, 4'b0111, 8'hBB));
    bus4.ReqB = 0;
    @(posedge clkN);
    check("race_reg3", {24'b0, bank4[3]}, 32'hBB);

    // Randomised traffic against the behavioural model
    clr = 1'b1;
    @(posedge clkN);
    clr = 1'b0;
    holdA = 0; holdB = 0;
    for (int c = 0; c < 400; c++) begin
      if (bus4.ReqA && bus4.AckA) holdA = ($urandom_range(0, 1) == 1);
      else if (bus4.ReqA) holdA = ($urandom_range(0, 9) != 0);
      else holdA = ($urandom_range(0, 1) == 1);
      if (bus4.ReqB && bus4.AckB) holdB = ($urandom_range(0, 1) == 1);
      else if (bus4.ReqB) holdB = ($urandom_range(0, 9) != 0);
      else holdB = ($urandom_range(0, 1) == 1);
      if (holdA && (!bus4.ReqA || bus4.AckA)) begin
        bus4.AddrA = 2'($urandom_range(0, 3));
        bus4.DataA = 8'($urandom);
      end
      if (holdB && (!bus4.ReqB || bus4.AckB)) begin
        bus4.AddrB = 2'($urandom_range(0, 3));
        bus4.DataB = 8'($urandom);
      end
      bus4.ReqA = holdA;
      bus4.ReqB = holdB;
      @(posedge clkN);
      check($sformatf("rand_out_c%0d", c), out4(), exp4(mAckA, mAckB, mErr, mEnbar, mDout));
      check($sformatf("rand_bank_c%0d", c), bankWord(), {mBank[3], mBank[2], mBank[1], mBank[0]});
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/register_bank_write_arbiter.md
# register_bank_write_arbiter

Shares one bank of negative-edge, active-low-load-enable 8-bit registers between two independent writers (A and B). Per cycle it grants at most one pending write with round-robin fairness and drives the bank's shared data bus and one-hot active-low load enables. It gives each writer a one-cycle acknowledge. It sits between the writers and the register bank and is the only driver of the bank's load enables.

## Interface
Parameters:
- WIDTH, 8, data width of each bank register
- NREG, 4, number of registers in the bank
- ADDRW, 2, register address width; NREG ≤ 2^ADDRW

Ports:
- ClkN  in  1  clock; all state updates on falling edge
- Clr  in  1  asynchronous, active-high reset
- ReqA  in  1  writer A request, level
- AddrA  in  ADDRW  writer A target register
- DataA  in  WIDTH  writer A write data
- AckA  out  1  writer A granted, one-cycle pulse
- ReqB / AddrB / DataB / AckB  same as A, for writer B
- Dout  out  WIDTH  shared data bus to every bank register D input
- Enbar  out  NREG  per-register load enable, active-low, at most one bit low
- Err  out  1  one-cycle pulse: granted write had AddrX ≥ NREG

## Operation
- State: GrantLast (1 = B granted last), registered AckA, AckB, Dout, Enbar, Err.
- Eligibility: writer X is eligible when ReqX=1 and AckX=0. A writer is never granted on two consecutive edges.
- Arbitration, each falling edge:
  - only A eligible -> grant A
  - only B eligible -> grant B
  - both eligible -> grant the writer not equal to GrantLast
  - neither eligible -> idle
- On grant of X with AddrX < NREG:
  - Dout <= DataX
  - Enbar <= all 1 except bit AddrX = 0
  - AckX <= 1, other Ack <= 0
  - GrantLast <= X
- On grant of X with AddrX ≥ NREG:
  - AckX <= 1, Err <= 1
  - Enbar <= all 1
  - Dout holds its value
  - GrantLast <= X
- Idle: Enbar <= all 1, AckA=AckB=Err <= 0, Dout holds.
- Handshake: the writer keeps ReqX, AddrX and DataX stable until it samples AckX=1. In the cycle AckX is high, the writer drops ReqX or presents its next transaction. The arbiter ignores ReqX in that cycle.
- Request withdrawal before Ack is legal. No grant is issued if ReqX is low at the edge.

## Timing
- Reset (Clr=1, asynchronous, immediate): Enbar = all 1, AckA = AckB = Err = 0, Dout = 0, GrantLast = 1 (A wins first contention). No bank register can load while Clr=1.
- Reset mid-grant: the pending Enbar low bit and Ack are cancelled immediately. The write is lost, and the writer re-requests after Clr falls.
- Latency:
  - ReqX sampled at edge k -> AckX, Enbar, Dout valid after edge k.
  - The bank loads at edge k+1.
- Throughput:
  - one write per cycle aggregate
  - one write per 2 cycles per writer
  - under continuous contention, strict A/B alternation
- All outputs come directly from flip-flops. No combinational path from inputs to outputs.
- Simultaneous A and B requests to the same address: both are serviced in grant order, and the later write wins in the bank.

## Structure
- Shared include file (guarded, as for other blocks) holds:
  - default WIDTH/NREG/ADDRW
  - the GrantLast encoding constants (GRANT_A=0, GRANT_B=1)
- Sub-module rr_arbiter2:
  - inputs: two eligibility bits and GrantLast
  - outputs: one-hot two-bit grant
  - purely combinational, reused by later multi-writer blocks
- Top level contains:
  - the eligibility logic
  - the address decoder (address → one-hot active-low enable, with range check)
  - output registers

## Test plan
- Reset: Clr=1 with ReqA=ReqB=1 -> Enbar=4'b1111, AckA=AckB=0, Dout=8'h00 throughout. Release Clr -> first grant to A.
- Single write: ReqA=1, AddrA=2, DataA=8'h5A at edge k -> after edge k Enbar=4'b1011, Dout=8'h5A, AckA=1 for exactly one cycle. Bank register 2 holds 8'h5A after edge k+1.
- Contention, both writers held continuously:
  - inputs: A at addr 0 data 8'h11, B at addr 1 data 8'h22
  - required response: grants A,B,A,B on successive edges, Enbar alternating 4'b1110/4'b1101, with no missed cycle.
- Out-of-range address: NREG=3 build, ReqB=1, AddrB=3 -> AckB=1, Err=1 for one cycle, Enbar=all 1, Dout unchanged.
- Reset mid-grant: assert Clr in the cycle where Enbar=4'b0111 -> Enbar goes to 4'b1111 before the next falling edge. The target register keeps its old value, and AckA=0 immediately.
- Same-address race: A writes 8'hAA and B writes 8'hBB, both to addr 3, simultaneously after reset -> the bank's register 3 ends at 8'hBB. AckA precedes AckB by one cycle.
